leaf_msg_endpoint: RTL and testbench
====================================

// Module: leaf_msg_endpoint
// PURPOSE
//  Leaf-FPGA end of the root-hub link. Accepts 64-bit downlink words from the root hub,
//  applies CONFIG words to the local decoder and launches it on START. Times each decode
//  and returns one LATENCY word per START on the uplink. Sits between the leaf link FIFO
//  pair and the leaf decoder core.
// PARAMETERS
//  FPGA_ID      1      this leaf's destination id (compared to msg[63:56])
//  MAX_COUNT    1000   decode timeout in cycles; 1..65535
//  ROOT_ID      0      destination id written into uplink replies
// PORTS
//  clk         in   1   single clock
//  reset_n     in   1   asynchronous, active-low reset
//  rx_data     in   64  downlink word from root hub
//  rx_valid    in   1   rx_data valid
//  rx_ready    out  1   endpoint accepts rx_data this cycle
//  tx_data     out  64  uplink word to root hub
//  tx_valid    out  1   tx_data valid
//  tx_ready    in   1   root hub accepts tx_data this cycle
//  cfg_data    out  32  last accepted CONFIG payload
//  cfg_valid   out  1   1-cycle pulse when cfg_data updates
//  dec_start   out  1   1-cycle decoder launch pulse
//  dec_done    in   1   1-cycle decoder completion pulse
//  drop_count  out  16  saturating count of discarded downlink words
// BEHAVIOUR
//  Word format: [63:56] dest, [55:48] type, [47:0] payload.
//  Types: CONFIG=8'h01, START=8'h02, LATENCY=8'h10 (uplink only).
//  Transfer occurs on valid&&ready at posedge clk. A word is accepted only by a transfer.
//  Reset (async, any state): state=IDLE. Outputs: rx_ready=0, tx_valid=0, tx_data=0,
//   cfg_data=0, cfg_valid=0, dec_start=0, drop_count=0. rx_ready goes 1 one cycle after release.
//  FSM IDLE: rx_ready=1.
//   - Accepted word, dest!=FPGA_ID or unknown type: dropped; drop_count+1, saturates at 16'hFFFF.
//   - CONFIG: cfg_data<=payload[31:0]; cfg_valid pulses on the next cycle; stay IDLE.
//   - START: -> RUN; lat_cnt<=0.
//  FSM RUN: rx_ready=0.
//   - dec_start=1 in the first RUN cycle only (cycle T).
//   - lat_cnt increments every cycle after T.
//   - dec_done sampled from cycle T inclusive; done at T+k captures latency=k.
//     Done in cycle T itself gives latency=0. -> REPORT, timeout=0.
//   - lat_cnt==MAX_COUNT with no dec_done -> REPORT, latency=MAX_COUNT, timeout=1.
//   - dec_done and timeout in the same cycle: done wins (timeout=0).
//  FSM REPORT: rx_ready=0; tx_valid=1.
//   - tx_data = {ROOT_ID[7:0], 8'h10, 31'b0, timeout, latency[15:0]}.
//   - tx_data stays stable while tx_valid && !tx_ready.
//   - On tx_ready: tx_valid=0 the next cycle; -> IDLE.
//   - dec_done while in REPORT or IDLE: ignored.
//  Latency from START acceptance to tx_valid: dec latency + 2 cycles.
//  Only one decode in flight; downlink is back-pressured during RUN/REPORT; no words are lost.
//  Registered outputs only. No combinational path from rx_valid/tx_ready to any output.
// STRUCTURE
//  Package qec_msg_pkg: field offsets, MSG_CONFIG/MSG_START/MSG_LATENCY constants,
//   typedef enum {IDLE,RUN,REPORT} leaf_state_t, typedef struct packed msg_word_t.
//  Sub-module sat_counter #(WIDTH): inc/clear, saturating. Used for drop_count and lat_cnt.
// TESTING
//  1 CONFIG {01,01,48'h0000_DEADBEEF} -> cfg_data=32'hDEADBEEF, cfg_valid one pulse;
//    no uplink word; drop_count=0.
//  2 START, dec_done 37 cycles after dec_start, tx_ready=1
//    -> tx_data=64'h0010_0000_0000_0025 (latency 37, timeout 0); exactly one uplink word.
//  3 START, dec_done never, MAX_COUNT=1000
//    -> tx_data=64'h0010_0000_0001_03E8 (latency 1000, timeout 1); dec_done arriving later ignored.
//  4 START, dec_done after 5 cycles, tx_ready=0 for 20 cycles
//    -> tx_valid held, tx_data stable; second START stalled (rx_ready=0) and accepted after drain.
//  5 Words with dest=8'h07 and with type=8'h55 -> both accepted, dropped; drop_count=2.
//  6 reset_n low mid-RUN -> immediate IDLE outputs as listed, drop_count=0;
//    after release START works normally.

Source files
------------

// File: rtl/qec_msg_pkg.sv
// Shared message layout for the root-hub link: field positions, message
// types, the leaf endpoint state set and the uplink reply builder.
package qec_msg_pkg;

  localparam int MSG_W     = 64;
  localparam int DEST_LSB  = 56;
  localparam int TYPE_LSB  = 48;
  localparam int PAYLOAD_W = 48;
  localparam int CFG_W     = 32;
  localparam int LAT_W     = 16;

  localparam logic [7:0] MSG_CONFIG  = 8'h01;
  localparam logic [7:0] MSG_START   = 8'h02;
  localparam logic [7:0] MSG_LATENCY = 8'h10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } leaf_state_t;

  typedef struct packed {
    logic [7:0]           dest;
    logic [7:0]           mtype;
    logic [PAYLOAD_W-1:0] payload;
  } msg_word_t;

  // Uplink LATENCY word: {dest, type, 31 zero bits, timeout flag, latency}.
  function automatic logic [MSG_W-1:0] make_latency_msg(
    input logic [7:0]       dest,
    input logic             timeout,
    input logic [LAT_W-1:0] latency
  );
    return {dest, MSG_LATENCY, 31'b0, timeout, latency};
  endfunction

endpackage

// File: rtl/leaf_msg_endpoint_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over inc.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  // Next count: clear, else increment unless already at all-ones.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/leaf_msg_endpoint.sv
// Leaf end of the root-hub link. Downlink CONFIG words update cfg_data,
// START words launch the decoder and time it; each START produces exactly
// one LATENCY word on the uplink.
//
// Handshake: a word moves on a channel only in a cycle where both valid and
// ready are high at posedge clk. The source holds data stable while valid is
// high and ready is low. All outputs here are registered, so rx_ready and
// tx_valid never depend combinationally on rx_valid or tx_ready.
module leaf_msg_endpoint
  import qec_msg_pkg::*;
#(
  parameter logic [7:0] FPGA_ID   = 8'd1,
  parameter int         MAX_COUNT = 1000,
  parameter logic [7:0] ROOT_ID   = 8'd0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [MSG_W-1:0]  rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [MSG_W-1:0]  tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [CFG_W-1:0]  cfg_data,
  output logic              cfg_valid,
  output logic              dec_start,
  input  logic              dec_done,
  output logic [LAT_W-1:0]  drop_count,
  output leaf_state_t       dbg_state
);

  leaf_state_t      state_q, state_d;
  logic             rx_ready_q, rx_ready_d;
  logic             tx_valid_q, tx_valid_d;
  logic [MSG_W-1:0] tx_data_q, tx_data_d;
  logic [CFG_W-1:0] cfg_data_q, cfg_data_d;
  logic             cfg_valid_q, cfg_valid_d;
  logic             dec_start_q, dec_start_d;

  logic             lat_inc, lat_clr;
  logic [LAT_W-1:0] lat_cnt;

  msg_word_t rx_msg;
  logic      rx_fire, tx_fire;
  logic      dest_ok, is_cfg, is_start, is_drop, lat_max;
  logic      unused_payload_hi;

  assign rx_msg   = rx_data;
  assign rx_fire  = rx_valid && rx_ready_q;
  assign tx_fire  = tx_valid_q && tx_ready;
  assign dest_ok  = (rx_msg.dest == FPGA_ID);
  assign is_cfg   = rx_fire && dest_ok && (rx_msg.mtype == MSG_CONFIG);
  assign is_start = rx_fire && dest_ok && (rx_msg.mtype == MSG_START);
  // Anything accepted that is not a CONFIG/START for this leaf is discarded,
  // including uplink-only LATENCY words echoed downstream.
  assign is_drop  = rx_fire && !is_cfg && !is_start;
  assign lat_max  = (lat_cnt == LAT_W'(MAX_COUNT));

  assign unused_payload_hi = ^rx_msg.payload[PAYLOAD_W-1:CFG_W];

  // Discarded downlink words; never cleared except by reset.
  sat_counter #(.WIDTH(LAT_W)) u_drop_cnt (
    .clk     (clk),
    .rst_n   (reset_n),
    .clear_i (1'b0),
    .inc_i   (is_drop),
    .count_o (drop_count)
  );

  // Decode timer: zero during the launch cycle, k in the k-th cycle after it.
  sat_counter #(.WIDTH(LAT_W)) u_lat_cnt (
    .clk     (clk),
    .rst_n   (reset_n),
    .clear_i (lat_clr),
    .inc_i   (lat_inc),
    .count_o (lat_cnt)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_d     = state_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    cfg_data_d  = cfg_data_q;
    cfg_valid_d = 1'b0;
    dec_start_d = 1'b0;
    lat_inc     = 1'b0;
    lat_clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_cfg) begin
          cfg_data_d  = rx_msg.payload[CFG_W-1:0];
          cfg_valid_d = 1'b1;
        end else if (is_start) begin
          state_d     = RUN;
          lat_clr     = 1'b1;
          dec_start_d = 1'b1;
        end
      end
      RUN: begin
        // Completion beats timeout when both land in the same cycle.
        if (dec_done) begin
          state_d    = REPORT;
          tx_valid_d = 1'b1;
          tx_data_d  = make_latency_msg(ROOT_ID, 1'b0, lat_cnt);
        end else if (lat_max) begin
          state_d    = REPORT;
          tx_valid_d = 1'b1;
          tx_data_d  = make_latency_msg(ROOT_ID, 1'b1, lat_cnt);
        end else begin
          lat_inc = 1'b1;
        end
      end
      REPORT: begin
        if (tx_fire) begin
          state_d    = IDLE;
          tx_valid_d = 1'b0;
        end
      end
      default: begin
        state_d    = IDLE;
        tx_valid_d = 1'b0;
      end
    endcase
    // Downlink is open only while idle; registered, so it follows the state.
    rx_ready_d = (state_d == IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rx_ready_q  <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      cfg_data_q  <= '0;
      cfg_valid_q <= 1'b0;
      dec_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_ready_q  <= rx_ready_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      cfg_data_q  <= cfg_data_d;
      cfg_valid_q <= cfg_valid_d;
      dec_start_q <= dec_start_d;
    end
  end

  assign rx_ready  = rx_ready_q;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign cfg_data  = cfg_data_q;
  assign cfg_valid = cfg_valid_q;
  assign dec_start = dec_start_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_leaf_msg_endpoint.sv
// Bench for leaf_msg_endpoint: directed scenarios followed by random traffic,
// all checked against a transaction-level model of the endpoint.
module tb_leaf_msg_endpoint;

  localparam int MAXC = 1000;

  // ---------------- clock / reset ----------------
  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] rx_data  = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [63:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [31:0] cfg_data;
  logic        cfg_valid;
  logic        dec_start;
  logic        dec_done = 1'b0;
  logic [15:0] drop_count;
  logic [1:0]  dbg_state;

  leaf_msg_endpoint #(
    .FPGA_ID   (8'h01),
    .MAX_COUNT (MAXC),
    .ROOT_ID   (8'h00)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .cfg_data   (cfg_data),
    .cfg_valid  (cfg_valid),
    .dec_start  (dec_start),
    .dec_done   (dec_done),
    .drop_count (drop_count),
    .dbg_state  (dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- decoder model ----------------
  // dec_delay: cycles from the launch cycle to the done pulse; -1 = never.
  int dec_delay = 0;
  int dcnt      = -1;
  always @(posedge clk) begin
    #1;
    if (!reset_n)       dcnt = -1;
    else if (dec_start) dcnt = dec_delay;
    else if (dcnt >= 0) dcnt = dcnt - 1;
    dec_done = (dcnt == 0);
  end

  // ---------------- uplink back-pressure ----------------
  // 0: always ready, 1: random, 2: held low
  int tx_mode = 0;
  always @(posedge clk) begin
    #1;
    case (tx_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = 1'($urandom_range(0, 1));
      default: tx_ready = 1'b0;
    endcase
  end

  // ---------------- reference model + scoreboard ----------------
  logic [63:0] exp_q[$];
  int          cyc       = 0;
  logic        m_busy    = 1'b0;
  logic        m_pend    = 1'b0;
  int          m_tx_at   = 0;
  logic        e_rdy     = 1'b0;
  logic        e_cfgv    = 1'b0;
  logic        e_start   = 1'b0;
  logic        e_txv     = 1'b0;
  logic [31:0] e_cfg     = '0;
  logic [15:0] e_drop    = '0;
  logic        hold_v    = 1'b0;
  logic [63:0] hold_data = '0;
  logic [63:0] last_tx   = '0;
  int          tx_count  = 0;
  int          cfgv_cnt  = 0;
  logic [7:0]  m_dest, m_type;
  int          m_lat;
  logic        m_to;

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      check("rst_rx_ready",   64'(rx_ready),   64'd0);
      check("rst_tx_valid",   64'(tx_valid),   64'd0);
      check("rst_tx_data",    tx_data,         64'd0);
      check("rst_cfg_data",   64'(cfg_data),   64'd0);
      check("rst_cfg_valid",  64'(cfg_valid),  64'd0);
      check("rst_dec_start",  64'(dec_start),  64'd0);
      check("rst_drop_count", 64'(drop_count), 64'd0);
      exp_q.delete();
      m_busy = 0; m_pend = 0; hold_v = 0;
      e_rdy = 0; e_cfgv = 0; e_start = 0; e_txv = 0; e_cfg = '0; e_drop = '0;
    end else begin
      check("rx_ready",   64'(rx_ready),   64'(e_rdy));
      check("cfg_valid",  64'(cfg_valid),  64'(e_cfgv));
      check("cfg_data",   64'(cfg_data),   64'(e_cfg));
      check("dec_start",  64'(dec_start),  64'(e_start));
      check("drop_count", 64'(drop_count), 64'(e_drop));
      check("tx_valid",   64'(tx_valid),   64'(e_txv));
      if (cfg_valid) cfgv_cnt++;
      if (hold_v && tx_valid) check("tx_hold", tx_data, hold_data);
      hold_v    = tx_valid && !tx_ready;
      hold_data = tx_data;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) check("tx_unexpected", 64'(exp_q.size()), 64'd1);
        else                   check("tx_data", tx_data, exp_q.pop_front());
        last_tx = tx_data;
        tx_count++;
        m_busy = 0;
        m_pend = 0;
      end
      e_cfgv  = 0;
      e_start = 0;
      if (rx_valid && rx_ready) begin
        m_dest = rx_data[63:56];
        m_type = rx_data[55:48];
        if (m_dest == 8'h01 && m_type == 8'h01) begin
          e_cfg  = rx_data[31:0];
          e_cfgv = 1;
        end else if (m_dest == 8'h01 && m_type == 8'h02) begin
          if (dec_delay >= 0 && dec_delay <= MAXC) begin m_lat = dec_delay; m_to = 0; end
          else begin m_lat = MAXC; m_to = 1; end
          exp_q.push_back({8'h00, 8'h10, 31'b0, m_to, 16'(m_lat)});
          m_busy  = 1;
          m_pend  = 1;
          m_tx_at = cyc + m_lat + 2;
          e_start = 1;
        end else if (e_drop != 16'hFFFF) begin
          e_drop = e_drop + 16'd1;
        end
      end
      e_rdy = !m_busy;
      e_txv = m_pend && (cyc + 1 >= m_tx_at);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [63:0] w, input int delay);
    int n = 0;
    @(posedge clk); #1;
    dec_delay = delay;
    rx_data   = w;
    rx_valid  = 1'b1;
    while (!rx_ready && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rx_ready) check("rx_accept_timeout", 64'(rx_ready), 64'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = {$urandom, $urandom};
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_busy || exp_q.size() != 0) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout", 64'(m_busy), 64'd0);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic spurious_done();
    @(posedge clk); #2;
    dec_done = 1'b1;
    @(posedge clk); #2;
  endtask

  // ---------------- global time bound ----------------
  initial begin
    #3ms;
    $display("FAIL watchdog simulation did not finish in time");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  int txc0;
  int cfc0;
  logic [7:0]  r_dest, r_type;
  int          r_sel, r_delay;

  initial begin
    wait_cycles(3);
    reset_n = 1'b1;
    wait_cycles(3);

    // 1: CONFIG, plus a stray dec_done while idle
    txc0 = tx_count; cfc0 = cfgv_cnt;
    send_word({8'h01, 8'h01, 48'h0000_DEADBEEF}, 0);
    wait_cycles(3);
    spurious_done();
    wait_cycles(3);
    check("t1_cfg_data",   64'(cfg_data),          64'hDEADBEEF);
    check("t1_cfg_pulses", 64'(cfgv_cnt - cfc0),   64'd1);
    check("t1_no_uplink",  64'(tx_count - txc0),   64'd0);
    check("t1_drop",       64'(drop_count),        64'd0);

    // 2: START, done 37 cycles after launch
    txc0 = tx_count;
    send_word({8'h01, 8'h02, 48'h0}, 37);
    wait_idle();
    wait_cycles(5);
    check("t2_tx_data", last_tx, 64'h0010_0000_0000_0025);
    check("t2_one_word", 64'(tx_count - txc0), 64'd1);

    // 3: START, done too late -> timeout; the late done lands in IDLE
    txc0 = tx_count;
    send_word({8'h01, 8'h02, 48'h0}, MAXC + 5);
    wait_idle();
    wait_cycles(12);
    check("t3_tx_data", last_tx, 64'h0010_0000_0001_03E8);
    check("t3_one_word", 64'(tx_count - txc0), 64'd1);

    // 4: uplink held off for 20 cycles; second START waits for the drain
    txc0 = tx_count;
    tx_mode = 2;
    send_word({8'h01, 8'h02, 48'h0}, 5);
    fork
      begin
        wait_cycles(28);
        tx_mode = 0;
      end
      send_word({8'h01, 8'h02, 48'h0}, 9);
    join
    wait_idle();
    wait_cycles(3);
    check("t4_last_tx", last_tx, 64'h0010_0000_0000_0009);
    check("t4_two_words", 64'(tx_count - txc0), 64'd2);

    // 5: wrong destination and unknown type are dropped
    send_word({8'h07, 8'h01, 48'h0000_12345678}, 0);
    send_word({8'h01, 8'h55, 48'h0000_CAFEF00D}, 0);
    wait_cycles(3);
    check("t5_drop", 64'(drop_count), 64'd2);
    check("t5_cfg_kept", 64'(cfg_data), 64'hDEADBEEF);

    // 6: reset in the middle of a decode
    send_word({8'h01, 8'h02, 48'h0}, -1);
    wait_cycles(50);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("t6_async_rx_ready",  64'(rx_ready),   64'd0);
    check("t6_async_dec_start", 64'(dec_start),  64'd0);
    check("t6_async_tx_valid",  64'(tx_valid),   64'd0);
    check("t6_async_drop",      64'(drop_count), 64'd0);
    check("t6_async_cfg",       64'(cfg_data),   64'd0);
    wait_cycles(3);
    reset_n = 1'b1;
    txc0 = tx_count;
    send_word({8'h01, 8'h02, 48'h0}, 0);
    wait_idle();
    wait_cycles(3);
    check("t6_after_reset", last_tx, 64'h0010_0000_0000_0000);
    check("t6_one_word", 64'(tx_count - txc0), 64'd1);

    // random traffic with random uplink back-pressure
    tx_mode = 1;
    for (int i = 0; i < 40; i++) begin
      r_dest = ($urandom_range(0, 4) == 0) ? 8'h07 : 8'h01;
      r_sel  = $urandom_range(0, 4);
      case (r_sel)
        0:       r_type = 8'h01;
        1, 2:    r_type = 8'h02;
        3:       r_type = 8'h55;
        default: r_type = 8'h10;
      endcase
      r_sel = $urandom_range(0, 19);
      if (r_sel == 0)      r_delay = -1;
      else if (r_sel == 1) r_delay = MAXC;
      else if (r_sel == 2) r_delay = MAXC - 1;
      else                 r_delay = $urandom_range(0, 40);
      send_word({r_dest, r_type, 16'h0, $urandom}, r_delay);
    end
    wait_idle();
    tx_mode = 0;
    wait_cycles(5);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
